de_scoreboard: RTL

- Parametrised register scoreboard for the decode stage.
- Replaces the fixed compare of source IDs against the rd of AGEX/MEM/WB with a per-register pending-write counter, so the number of in-flight writers and the read-port count are generic.
- Issue increments the counter for the destination; writeback decrements it; decode stalls while any source is pending.
- Adds flush, saturation stall, an underflow error flag and a stall-cycle counter.

---
 rtl/de_scoreboard_pkg.sv | 20 ++
 rtl/de_scoreboard_sb_cnt.sv | 51 +++++
 rtl/de_scoreboard.sv | 127 ++++++++++++
 3 files changed

// File: rtl/de_scoreboard_pkg.sv
// Shared constants and helpers for the decode-stage register scoreboard.
package de_scoreboard_pkg;

    localparam int NREGS_DEFAULT     = 32;
    localparam int REGNOBITS_DEFAULT = 5;
    localparam int NRD_DEFAULT       = 2;
    localparam int CNTBITS_DEFAULT   = 2;
    localparam int STATBITS_DEFAULT  = 32;

    // Largest value a pending counter of the given width can hold.
    function automatic int cnt_max(input int cntbits);
        return (1 << cntbits) - 1;
    endfunction

    // LSB of read port k inside the packed src_id bus.
    function automatic int src_lsb(input int k, input int regnobits);
        return k * regnobits;
    endfunction

endpackage

// File: rtl/de_scoreboard_sb_cnt.sv
// One saturating pending-write counter with increment, decrement and clear.
module sb_cnt
    import de_scoreboard_pkg::*;
#(
    parameter int CNTBITS = CNTBITS_DEFAULT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               inc_i,
    input  logic               dec_i,
    input  logic               clr_i,
    output logic [CNTBITS-1:0] cnt_o,
    output logic               nonzero_o,
    output logic               full_o,
    output logic               nxt_nonzero_o
);

    localparam logic [CNTBITS-1:0] MAX = CNTBITS'(cnt_max(CNTBITS));

    logic [CNTBITS-1:0] cnt_q;
    logic [CNTBITS-1:0] cnt_d;

    assign nonzero_o     = (cnt_q != {CNTBITS{1'b0}});
    assign full_o        = (cnt_q == MAX);
    assign cnt_o         = cnt_q;
    assign nxt_nonzero_o = (cnt_d != {CNTBITS{1'b0}});

    // Next count: clear wins, a matched inc/dec pair cancels, never wrap.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = {CNTBITS{1'b0}};
        end else if (inc_i && !dec_i && !full_o) begin
            cnt_d = cnt_q + CNTBITS'(1);
        end else if (dec_i && !inc_i && nonzero_o) begin
            cnt_d = cnt_q - CNTBITS'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= {CNTBITS{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/de_scoreboard.sv
// Decode-stage register scoreboard built from per-register pending-write counters.
// Optional build macro DE_SCOREBOARD_WB_BYPASS_EN lets a same-cycle last writeback satisfy a read.
module de_scoreboard
    import de_scoreboard_pkg::*;
#(
    parameter int NREGS     = NREGS_DEFAULT,
    parameter int REGNOBITS = REGNOBITS_DEFAULT,
    parameter int NRD       = NRD_DEFAULT,
    parameter int CNTBITS   = CNTBITS_DEFAULT,
    parameter int STATBITS  = STATBITS_DEFAULT
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     issue_valid,
    input  logic                     issue_wr,
    input  logic [REGNOBITS-1:0]     issue_rd,
    input  logic [NRD-1:0]           src_valid,
    input  logic [NRD*REGNOBITS-1:0] src_id,
    input  logic                     wb_valid,
    input  logic [REGNOBITS-1:0]     wb_rd,
    input  logic                     flush,
    output logic                     stall,
    output logic                     issue_fire,
    output logic                     busy,
    output logic                     err_underflow,
    output logic [STATBITS-1:0]      stall_cycles
);

    localparam int NSLOTS = 1 << REGNOBITS;

    logic [CNTBITS-1:0]   cnt_s    [NSLOTS];
    logic [NSLOTS-1:0]    nz_s;
    logic [NSLOTS-1:0]    full_s;
    logic [NSLOTS-1:0]    nxt_nz_s;
    logic [REGNOBITS-1:0] src_id_s [NRD];
    logic                 src_pend_s;
    logic                 sat_s;
    logic                 underflow_s;
    logic                 busy_q, busy_d;
    logic                 err_q, err_d;
    logic [STATBITS-1:0]  stall_cycles_q, stall_cycles_d;

    for (genvar k = 0; k < NRD; k++) begin : g_src
        assign src_id_s[k] = src_id[src_lsb(k, REGNOBITS) +: REGNOBITS];
    end

    // Slot 0 and IDs beyond NREGS are tied to an empty, never-full counter.
    for (genvar r = 0; r < NSLOTS; r++) begin : g_reg
        if (r >= 1 && r < NREGS) begin : g_cnt
            logic inc_s;
            logic dec_s;
            assign inc_s = issue_fire && issue_wr && (issue_rd == REGNOBITS'(r));
            assign dec_s = wb_valid && (wb_rd == REGNOBITS'(r)) && nz_s[r];
            sb_cnt #(.CNTBITS(CNTBITS)) u_cnt (
                .clk           (clk),
                .rst_n         (reset_n),
                .inc_i         (inc_s),
                .dec_i         (dec_s),
                .clr_i         (flush),
                .cnt_o         (cnt_s[r]),
                .nonzero_o     (nz_s[r]),
                .full_o        (full_s[r]),
                .nxt_nonzero_o (nxt_nz_s[r])
            );
        end else begin : g_zero
            assign cnt_s[r]    = {CNTBITS{1'b0}};
            assign nz_s[r]     = 1'b0;
            assign full_s[r]   = 1'b0;
            assign nxt_nz_s[r] = 1'b0;
        end
    end

    // Source hazard check across all read ports.
    always_comb begin
        src_pend_s = 1'b0;
        for (int k = 0; k < NRD; k++) begin
            if (src_valid[k] && nz_s[src_id_s[k]]) begin
`ifdef DE_SCOREBOARD_WB_BYPASS_EN
                if (wb_valid && (wb_rd == src_id_s[k]) &&
                    (cnt_s[src_id_s[k]] == CNTBITS'(1))) begin
                    src_pend_s = src_pend_s;
                end else begin
                    src_pend_s = 1'b1;
                end
`else
                src_pend_s = 1'b1;
`endif
            end else begin
                src_pend_s = src_pend_s;
            end
        end
    end

    assign sat_s       = issue_wr && (issue_rd != {REGNOBITS{1'b0}}) && full_s[issue_rd];
    assign stall       = issue_valid && (src_pend_s || sat_s);
    assign issue_fire  = issue_valid && !stall && !flush;
    assign underflow_s = wb_valid && (wb_rd != {REGNOBITS{1'b0}}) && !nz_s[wb_rd];

    // Next state of the status registers.
    always_comb begin
        busy_d = |nxt_nz_s;
        err_d  = err_q || underflow_s;
        if (stall) begin
            stall_cycles_d = stall_cycles_q + STATBITS'(1);
        end else begin
            stall_cycles_d = stall_cycles_q;
        end
    end

    // Status registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy_q         <= 1'b0;
            err_q          <= 1'b0;
            stall_cycles_q <= {STATBITS{1'b0}};
        end else begin
            busy_q         <= busy_d;
            err_q          <= err_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign busy          = busy_q;
    assign err_underflow = err_q;
    assign stall_cycles  = stall_cycles_q;

endmodule
